// File: rtl/irq_pending_arbiter_if.sv
// irq_pending_arbiter_if: request/mask inputs, id handshake, EOI and status signals of the arbiter
interface irq_pending_arbiter_if;
  logic [7:0] req;
  logic [7:0] mask;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ready;
  logic       eoi;
  logic [2:0] eoi_id;
  logic       busy;
  logic [7:0] pending;
  logic       eoi_err;
  modport master (
    output req, mask, irq_ready, eoi, eoi_id,
    input  irq_valid, irq_id, busy, pending, eoi_err
  );
  modport slave (
    input  req, mask, irq_ready, eoi, eoi_id,
    output irq_valid, irq_id, busy, pending, eoi_err
  );
endinterface

// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: latches request rising edges, presents highest unmasked index, holds it until EOI
// Ports: clk, rst (async active-high); bus.req/mask in, bus.irq_valid/irq_id/irq_ready handshake,
// bus.eoi/eoi_id retire strobe, bus.busy/pending/eoi_err status out.
module irq_pending_arbiter (
  input logic clk,
  input logic rst,
  irq_pending_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;
  state_t     state;
  logic [7:0] req_q, pend, rise, clr, eligible;
  logic [2:0] sel, id;
  logic       valid, busy, err, accept, eoi_hit;
  always_comb begin
    rise     = bus.req & ~req_q;
    eligible = pend & ~bus.mask;
    accept   = state == PRESENT && bus.irq_ready;
    eoi_hit  = bus.eoi && state == SERVICE && bus.eoi_id == id;
    clr      = accept ? 8'b1 << id : 8'b0;
    sel      = 3'd0;
    for (int i = 0; i < 8; i++) if (eligible[i]) sel = 3'(i);
  end
  // a rise on the bit being accepted re-sets it, so the new event is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      pend  <= '0;
      state <= IDLE;
      valid <= 1'b0;
      id    <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      req_q <= bus.req;
      pend  <= (pend & ~clr) | rise;
      err   <= bus.eoi && !eoi_hit;
      case (state)
        IDLE: if (|eligible) begin
          id    <= sel;
          valid <= 1'b1;
          state <= PRESENT;
        end
        PRESENT: if (bus.irq_ready) begin
          valid <= 1'b0;
          busy  <= 1'b1;
          state <= SERVICE;
        end
        SERVICE: if (eoi_hit) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.irq_valid = valid;
  assign bus.irq_id    = id;
  assign bus.busy      = busy;
  assign bus.pending   = pend;
  assign bus.eoi_err   = err;
endmodule
